// File: rtl/reg_bus_master.sv
// Register-bus initiator: a byte-wide command stream becomes reg_* bursts; read bytes return on a byte-wide response stream.
// Optional macro REG_BUS_MASTER_WRACK_EN adds a one-byte 8'hA5 acknowledge after every write burst.
module reg_bus_master #(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pREAD_LATENCY = 1
) (
  input  logic                     cwusb_clk,
  input  logic                     reset_n,
  input  logic [7:0]               cmd_data,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  output logic [7:0]               rsp_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               write_data,
  input  logic [7:0]               read_data,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic                     reg_addrvalid,
  output logic                     busy
);

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_LEN,
    SETUP,
    WR_DATA,
    RD_STROBE,
    RD_WAIT,
    RD_SEND,
    DONE
`ifdef REG_BUS_MASTER_WRACK_EN
    , WR_ACK
`endif
  } state_t;

  // Index of the RD_WAIT cycle on which read_data is valid (latency 1..4).
  localparam logic [1:0] WAIT_LAST = 2'(pREAD_LATENCY - 1);
`ifdef REG_BUS_MASTER_WRACK_EN
  localparam logic [7:0] WR_ACK_BYTE = 8'hA5;
`endif

  state_t                   state_q, state_d;
  logic                     is_write_q, is_write_d;
  logic [8:0]               remaining_q, remaining_d;
  logic [1:0]               wait_cnt_q, wait_cnt_d;
  logic [7:0]               address_d;
  logic [7:0]               write_data_d;
  logic [7:0]               rsp_data_d;
  logic [pBYTECNT_SIZE-1:0] bytecnt_d;
  logic                     cmd_ready_d;
  logic                     rsp_valid_d;
  logic                     reg_read_d;
  logic                     reg_write_d;
  logic                     addrvalid_d;
  logic                     busy_d;
  logic                     cmd_fire;

  assign cmd_fire = cmd_valid & cmd_ready;

  // NOTE: every signal written here is given a default first, so no latch can be inferred.
  always_comb begin
    state_d      = state_q;
    is_write_d   = is_write_q;
    remaining_d  = remaining_q;
    wait_cnt_d   = wait_cnt_q;
    address_d    = reg_address;
    write_data_d = write_data;
    rsp_data_d   = rsp_data;
    bytecnt_d    = reg_bytecnt;
    reg_write_d  = 1'b0;

    // A write strobe on the bus now ends at this edge, so the index moves between strobes.
    if (reg_write) begin
      bytecnt_d = reg_bytecnt + pBYTECNT_SIZE'(1);
    end

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          is_write_d = cmd_data[7];
          state_d    = GET_ADDR;
        end
      end
      GET_ADDR: begin
        if (cmd_fire) begin
          address_d = cmd_data;
          state_d   = GET_LEN;
        end
      end
      GET_LEN: begin
        if (cmd_fire) begin
          remaining_d = (cmd_data == 8'd0) ? 9'd256 : {1'b0, cmd_data};
          bytecnt_d   = '0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        state_d = is_write_q ? WR_DATA : RD_STROBE;
      end
      WR_DATA: begin
        // remaining reaches zero on the last accept; the state lingers one
        // cycle so the final strobe still sees reg_addrvalid high.
        if (remaining_q == 9'd0) begin
`ifdef REG_BUS_MASTER_WRACK_EN
          rsp_data_d = WR_ACK_BYTE;
          state_d    = WR_ACK;
`else
          state_d    = DONE;
`endif
        end else if (cmd_fire) begin
          write_data_d = cmd_data;
          reg_write_d  = 1'b1;
          remaining_d  = remaining_q - 9'd1;
        end
      end
      RD_STROBE: begin
        wait_cnt_d = 2'd0;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          rsp_data_d = read_data;
          state_d    = RD_SEND;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      RD_SEND: begin
        if (rsp_ready) begin
          remaining_d = remaining_q - 9'd1;
          bytecnt_d   = reg_bytecnt + pBYTECNT_SIZE'(1);
          state_d     = (remaining_q == 9'd1) ? DONE : RD_STROBE;
        end
      end
`ifdef REG_BUS_MASTER_WRACK_EN
      WR_ACK: begin
        if (rsp_ready) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, so they line up with the state and cannot glitch.
    cmd_ready_d = (state_d == IDLE) || (state_d == GET_ADDR) || (state_d == GET_LEN) ||
                  ((state_d == WR_DATA) && (remaining_d != 9'd0));
    reg_read_d  = (state_d == RD_STROBE);
    rsp_valid_d = (state_d == RD_SEND);
    addrvalid_d = (state_d == SETUP) || (state_d == WR_DATA) || (state_d == RD_STROBE) ||
                  (state_d == RD_WAIT) || (state_d == RD_SEND);
`ifdef REG_BUS_MASTER_WRACK_EN
    rsp_valid_d = rsp_valid_d || (state_d == WR_ACK);
    addrvalid_d = addrvalid_d || (state_d == WR_ACK);
`endif
    busy_d      = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, and every flop is reset.
  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      is_write_q    <= 1'b0;
      remaining_q   <= '0;
      wait_cnt_q    <= '0;
      reg_address   <= '0;
      reg_bytecnt   <= '0;
      write_data    <= '0;
      rsp_data      <= '0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      reg_read      <= 1'b0;
      reg_write     <= 1'b0;
      reg_addrvalid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_write_q    <= is_write_d;
      remaining_q   <= remaining_d;
      wait_cnt_q    <= wait_cnt_d;
      reg_address   <= address_d;
      reg_bytecnt   <= bytecnt_d;
      write_data    <= write_data_d;
      rsp_data      <= rsp_data_d;
      cmd_ready     <= cmd_ready_d;
      rsp_valid     <= rsp_valid_d;
      reg_read      <= reg_read_d;
      reg_write     <= reg_write_d;
      reg_addrvalid <= addrvalid_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: directed command streams, a register-block read model, and a queue scoreboard.
module tb_reg_bus_master;

  localparam int BCW = 7;
  localparam int LAT = 1;

  logic           cwusb_clk = 1'b0;
  logic           reset_n   = 1'b1;
  logic [7:0]     cmd_data  = 8'h00;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [7:0]     rsp_data;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [7:0]     reg_address;
  logic [BCW-1:0] reg_bytecnt;
  logic [7:0]     write_data;
  logic [7:0]     read_data = 8'h00;
  logic           reg_read;
  logic           reg_write;
  logic           reg_addrvalid;
  logic           busy;

  reg_bus_master #(.pBYTECNT_SIZE(BCW), .pREAD_LATENCY(LAT)) dut (
    .cwusb_clk     (cwusb_clk),
    .reset_n       (reset_n),
    .cmd_data      (cmd_data),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .rsp_data      (rsp_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .reg_address   (reg_address),
    .reg_bytecnt   (reg_bytecnt),
    .write_data    (write_data),
    .read_data     (read_data),
    .reg_read      (reg_read),
    .reg_write     (reg_write),
    .reg_addrvalid (reg_addrvalid),
    .busy          (busy)
  );

  always #5 cwusb_clk = ~cwusb_clk;

  // Register block model: read value is 0x40 + byte index, valid one cycle after the strobe.
  always @(posedge cwusb_clk) begin
    if (reg_read) read_data <= 8'h40 + 8'(reg_bytecnt);
  end

  typedef struct packed {
    logic [7:0]     addr;
    logic [BCW-1:0] cnt;
    logic [7:0]     data;
  } wr_exp_t;

  typedef struct packed {
    logic [7:0]     addr;
    logic [BCW-1:0] cnt;
  } rd_exp_t;

  wr_exp_t    exp_wr[$];
  rd_exp_t    exp_rd[$];
  logic [7:0] exp_rsp[$];
  wr_exp_t    got_wr;
  rd_exp_t    got_rd;
  logic [7:0] got_rsp;
  int         checks     = 0;
  int         errors     = 0;
  int         write_seen = 0;
  logic       prev_read  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [BCW-1:0] c, input logic [7:0] d);
    wr_exp_t e;
    e.addr = a; e.cnt = c; e.data = d;
    exp_wr.push_back(e);
  endtask

  task automatic push_rd(input logic [7:0] a, input logic [BCW-1:0] c);
    rd_exp_t e;
    e.addr = a; e.cnt = c;
    exp_rd.push_back(e);
    exp_rsp.push_back(8'h40 + 8'(c));
  endtask

  task automatic push_wr_ack();
`ifdef REG_BUS_MASTER_WRACK_EN
    exp_rsp.push_back(8'hA5);
`endif
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or a response byte.
  always @(negedge cwusb_clk) begin
    if (reset_n) begin
      if (reg_write) begin
        write_seen <= write_seen + 1;
        check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          got_wr = exp_wr.pop_front();
          check("wr_address", reg_address, got_wr.addr);
          check("wr_bytecnt", reg_bytecnt, got_wr.cnt);
          check("wr_data", write_data, got_wr.data);
          check("wr_addrvalid", reg_addrvalid, 1);
        end
      end
      if (reg_read) begin
        check("rd_low_gap", prev_read, 0);
        check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) begin
          got_rd = exp_rd.pop_front();
          check("rd_address", reg_address, got_rd.addr);
          check("rd_bytecnt", reg_bytecnt, got_rd.cnt);
          check("rd_addrvalid", reg_addrvalid, 1);
        end
      end
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", 32'(exp_rsp.size() != 0), 32'd1);
        if (exp_rsp.size() != 0) begin
          got_rsp = exp_rsp.pop_front();
          check("rsp_data", rsp_data, got_rsp);
        end
      end
      prev_read <= reg_read;
    end else begin
      prev_read <= 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(negedge cwusb_clk);
    while (!cmd_ready && n < 1000) begin
      @(negedge cwusb_clk);
      n++;
    end
    check("cmd_accept_timeout", cmd_ready, 1);
    @(posedge cwusb_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] l);
    send_byte(c);
    send_byte(a);
    send_byte(l);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge cwusb_clk);
    while (busy && n < 3000) begin
      @(negedge cwusb_clk);
      n++;
    end
    check({name, "_idle"}, busy, 0);
    check({name, "_addrvalid_low"}, reg_addrvalid, 0);
    check({name, "_wr_q_empty"}, exp_wr.size(), 0);
    check({name, "_rd_q_empty"}, exp_rd.size(), 0);
    check({name, "_rsp_q_empty"}, exp_rsp.size(), 0);
    @(posedge cwusb_clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_cmd_ready"}, cmd_ready, 0);
    check({name, "_rsp_valid"}, rsp_valid, 0);
    check({name, "_rsp_data"}, rsp_data, 0);
    check({name, "_reg_address"}, reg_address, 0);
    check({name, "_reg_bytecnt"}, reg_bytecnt, 0);
    check({name, "_write_data"}, write_data, 0);
    check({name, "_reg_read"}, reg_read, 0);
    check({name, "_reg_write"}, reg_write, 0);
    check({name, "_reg_addrvalid"}, reg_addrvalid, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state.
    #1 reset_n = 1'b0;
    repeat (3) @(negedge cwusb_clk);
    check_all_zero("reset");
    @(posedge cwusb_clk);
    #1 reset_n = 1'b1;
    @(posedge cwusb_clk);
    #1;

    // Write burst, data back-to-back.
    push_wr(8'h05, 7'd0, 8'h11);
    push_wr(8'h05, 7'd1, 8'h22);
    push_wr(8'h05, 7'd2, 8'h33);
    push_wr_ack();
    send_cmd(8'h80, 8'h05, 8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    wait_idle("wr3");

    // Read burst of four bytes.
    for (int i = 0; i < 4; i++) push_rd(8'h0C, BCW'(i));
    send_cmd(8'h00, 8'h0C, 8'h04);
    wait_idle("rd4");

    // Read with backpressure on byte 2.
    for (int i = 0; i < 4; i++) push_rd(8'h0C, BCW'(i));
    send_cmd(8'h00, 8'h0C, 8'h04);
    n = 0;
    while (!(rsp_valid && reg_bytecnt == 2) && n < 200) begin
      @(posedge cwusb_clk);
      #1;
      n++;
    end
    check("bp_reached", rsp_valid, 1);
    rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge cwusb_clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, 8'h42);
      check("bp_no_read", reg_read, 0);
      check("bp_bytecnt", reg_bytecnt, 2);
    end
    @(posedge cwusb_clk);
    #1 rsp_ready = 1'b1;
    wait_idle("bp");

    // LEN=0 write: 256 strobes, byte index wraps at 128.
    write_seen = 0;
    for (int i = 0; i < 256; i++) push_wr(8'h7E, BCW'(i), 8'(i * 3 + 1));
    push_wr_ack();
    send_cmd(8'h80, 8'h7E, 8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i * 3 + 1));
    wait_idle("len0");
    check("len0_write_count", write_seen, 256);
    check("len0_bytecnt_wrapped", reg_bytecnt, 0);

    // Reset during RD_WAIT of byte 1, then a normal one-byte read.
    for (int i = 0; i < 4; i++) push_rd(8'h21, BCW'(i));
    send_cmd(8'h00, 8'h21, 8'h04);
    n = 0;
    while (!(reg_read && reg_bytecnt == 1) && n < 200) begin
      @(posedge cwusb_clk);
      #1;
      n++;
    end
    check("rst_reached_byte1", reg_read, 1);
    @(posedge cwusb_clk);
    #1 reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_rd.delete();
    exp_rsp.delete();
    @(posedge cwusb_clk);
    #1 reset_n = 1'b1;
    @(posedge cwusb_clk);
    #1;
    push_rd(8'h01, 7'd0);
    send_cmd(8'h00, 8'h01, 8'h01);
    wait_idle("after_rst");

    // Write with a cmd_valid gap between data bytes.
    for (int i = 0; i < 3; i++) push_wr(8'h33, BCW'(i), 8'hAA + 8'(17 * i));
    push_wr_ack();
    send_cmd(8'h80, 8'h33, 8'h03);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hAA + 8'(17 * i));
      if (i < 2) begin
        @(negedge cwusb_clk);
        for (int g = 0; g < 4; g++) begin
          @(negedge cwusb_clk);
          check("gap_no_write", reg_write, 0);
          check("gap_addrvalid", reg_addrvalid, 1);
          check("gap_bytecnt", reg_bytecnt, i + 1);
        end
        @(posedge cwusb_clk);
        #1;
      end
    end
    wait_idle("gap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
